// File: rtl/ldr_str_ctrl.sv
// Load/store sequencer arbitrating a single-port data RAM between the CPU and a debug port.
// Optional LDR_STR_CNT_EN adds completed-load and completed-store counters.
module ldr_str_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [1:0]    cpu_op,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef LDR_STR_CNT_EN
  ,
  output logic [15:0]   ld_cnt,
  output logic [15:0]   st_cnt
`endif
);

  // state | meaning
  // IDLE  | sample requests, latch the winner
  // ISSUE | one-cycle mem_re / mem_we strobe
  // WAIT  | count down the memory latency, capture read data at zero
  // DONE  | pulse the owner's done (and cpu_err for op 11)
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] OP_LDR  = 2'b01;
  localparam logic [1:0] OP_STR  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;
  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_DBG = 1'b1;

  state_t     state, state_d;
  logic [3:0] cnt;
  logic       own;
  logic [1:0] op;
  logic       last_grant;

  logic       grant_any;
  logic       grant_dbg;
  logic [1:0] req_op;

  assign grant_any = cpu_req | dbg_req;
  assign grant_dbg = dbg_req & (~cpu_req | (last_grant == OWN_CPU));
  assign req_op    = grant_dbg ? (dbg_we ? OP_STR : OP_LDR) : cpu_op;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    cpu_done = 1'b0;
    cpu_err  = 1'b0;
    dbg_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_any)
          state_d = (req_op == OP_LDR || req_op == OP_STR) ? ISSUE : DONE;
      end
      ISSUE: begin
        mem_re  = (op == OP_LDR);
        mem_we  = (op == OP_STR);
        state_d = (op == OP_LDR) ? WAIT : DONE;
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = DONE;
      end
      DONE: begin
        cpu_done = (own == OWN_CPU);
        cpu_err  = (own == OWN_CPU) && (op == OP_ILL);
        dbg_done = (own == OWN_DBG);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      own        <= OWN_CPU;
      op         <= 2'b00;
      last_grant <= OWN_DBG;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        own        <= grant_dbg;
        op         <= req_op;
        last_grant <= grant_dbg;
        mem_addr   <= grant_dbg ? dbg_addr : cpu_addr;
        mem_wdata  <= grant_dbg ? dbg_wdata : cpu_wdata;
      end
      if (state == ISSUE) cnt <= 4'(MEM_LAT - 1);
      if (state == WAIT) begin
        if (cnt == 4'd0) begin
          if (own == OWN_CPU) cpu_rdata <= mem_rdata;
          else                dbg_rdata <= mem_rdata;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

`ifdef LDR_STR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt <= 16'd0;
      st_cnt <= 16'd0;
    end else if (state == DONE) begin
      if (op == OP_LDR) ld_cnt <= ld_cnt + 16'd1;
      if (op == OP_STR) st_cnt <= st_cnt + 16'd1;
    end
  end
`endif

endmodule
